// File: rtl/y_word_packer.sv
// Packs WIDTH qualified serial bits (first bit lands in the MSB) into a word on a valid/ready output.
// Define Y_WORD_PACKER_PARITY_EN to add a registered even-parity output, word_parity.
module y_word_packer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             y_in,
  input  logic             y_valid,
  input  logic             flush,
  input  logic             out_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic [CNT_W-1:0] ones_count,
  output logic             overflow
`ifdef Y_WORD_PACKER_PARITY_EN
  ,
  output logic             word_parity
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_word;
  logic [CNT_W-1:0] r_ones;
  logic             r_ovf;

  logic             w_sample;
  logic             w_complete;
  logic             w_fire;
  logic [WIDTH-1:0] w_word;
  logic [CNT_W-1:0] w_ones;

  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] w);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(w[i]);
    return c;
  endfunction

  // flush outranks y_valid, so a flushed sample can never complete a word
  assign w_sample   = y_valid && !flush;
  assign w_complete = w_sample && (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_word     = {r_shift[WIDTH-2:0], y_in};
  assign w_ones     = popcnt(w_word);
  assign w_fire     = (r_state == FULL) && out_ready;

`ifdef Y_WORD_PACKER_PARITY_EN
  logic r_parity;
  assign word_parity = r_parity;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_word    <= '0;
      r_ones    <= '0;
      r_ovf     <= 1'b0;
`ifdef Y_WORD_PACKER_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      if (flush) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (y_valid) begin
        r_shift   <= w_word;
        r_bit_cnt <= w_complete ? '0 : r_bit_cnt + 1'b1;
      end

      // A completing word loads when the slot is empty or being drained this cycle
      if (w_complete && (r_state == EMPTY || w_fire)) begin
        r_word   <= w_word;
        r_ones   <= w_ones;
`ifdef Y_WORD_PACKER_PARITY_EN
        r_parity <= ^w_word;
`endif
      end

      case (r_state)
        EMPTY: if (w_complete) r_state <= FULL;
        FULL: begin
          if (w_fire) begin
            if (!w_complete) r_state <= EMPTY;
          end else if (w_complete) begin
            r_ovf <= 1'b1;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign word_out   = r_word;
  assign word_valid = (r_state == FULL);
  assign ones_count = r_ones;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_y_word_packer.sv
// Directed bench for y_word_packer (WIDTH=8) with hand-computed expected words.
module tb_y_word_packer;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset;
  logic             y_in;
  logic             y_valid;
  logic             flush;
  logic             out_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic [CNT_W-1:0] ones_count;
  logic             overflow;
`ifdef Y_WORD_PACKER_PARITY_EN
  logic             word_parity;
`endif

  int checks   = 0;
  int failures = 0;

  y_word_packer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock      (clk),
    .reset      (reset),
    .y_in       (y_in),
    .y_valid    (y_valid),
    .flush      (flush),
    .out_ready  (out_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .ones_count (ones_count),
    .overflow   (overflow)
`ifdef Y_WORD_PACKER_PARITY_EN
    ,
    .word_parity(word_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send bits w[hi] down to w[lo]; optional idle gap after each sample
  task automatic send_bits(input logic [7:0] w, input int hi, input int lo, input bit gap);
    for (int i = hi; i >= lo; i--) begin
      y_valid = 1'b1;
      y_in    = w[i];
      step();
      y_valid = 1'b0;
      if (gap && i != lo) begin
        y_in = ~w[i];
        step();
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; y_in = 1'b0; y_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_word",  32'(word_out),   32'd0);
    chk("rst_ones",  32'(ones_count), 32'd0);
    chk("rst_ovf",   32'(overflow),   32'd0);

    // back-to-back samples
    out_ready = 1'b1;
    send_bits(8'hB2, 7, 1, 1'b0);
    chk("b2_not_yet", 32'(word_valid), 32'd0);
    send_bits(8'hB2, 0, 0, 1'b0);
    chk("b2_valid", 32'(word_valid), 32'd1);
    chk("b2_word",  32'(word_out),   32'hB2);
    chk("b2_ones",  32'(ones_count), 32'd4);
    chk("b2_ovf",   32'(overflow),   32'd0);
`ifdef Y_WORD_PACKER_PARITY_EN
    chk("b2_par",   32'(word_parity), 32'd0);
`endif
    step();
    chk("b2_drained", 32'(word_valid), 32'd0);

    // alternate-cycle gaps, gap-cycle y_in is the inverse of the real bit
    send_bits(8'hB2, 7, 0, 1'b1);
    chk("gap_valid", 32'(word_valid), 32'd1);
    chk("gap_word",  32'(word_out),   32'hB2);
    chk("gap_ones",  32'(ones_count), 32'd4);
    step();

    // backpressure: second word dropped
    out_ready = 1'b0;
    send_bits(8'hB2, 7, 0, 1'b0);
    chk("bp_first_valid", 32'(word_valid), 32'd1);
    send_bits(8'hFF, 7, 0, 1'b0);
    chk("bp_hold_word", 32'(word_out),   32'hB2);
    chk("bp_hold_ones", 32'(ones_count), 32'd4);
    chk("bp_ovf",       32'(overflow),   32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_drain_valid", 32'(word_valid), 32'd0);
    chk("bp_ovf_sticky",  32'(overflow),   32'd1);
    chk("bp_word_kept",   32'(word_out),   32'hB2);

    // fire and completion in the same cycle
    do_reset();
    chk("r2_ovf", 32'(overflow), 32'd0);
    send_bits(8'h0F, 7, 0, 1'b0);
    chk("0f_word", 32'(word_out), 32'h0F);
`ifdef Y_WORD_PACKER_PARITY_EN
    chk("0f_par", 32'(word_parity), 32'd0);
`endif
    send_bits(8'hF0, 7, 1, 1'b0);
    chk("0f_held", 32'(word_out), 32'h0F);
    out_ready = 1'b1;
    send_bits(8'hF0, 0, 0, 1'b0);
    out_ready = 1'b0;
    chk("f0_valid", 32'(word_valid), 32'd1);
    chk("f0_word",  32'(word_out),   32'hF0);
    chk("f0_ones",  32'(ones_count), 32'd4);
    chk("f0_ovf",   32'(overflow),   32'd0);

    // flush discards partial word and its own sample, output untouched
    send_bits(8'hFF, 7, 3, 1'b0);
    flush = 1'b1; y_valid = 1'b1; y_in = 1'b1;
    step();
    flush = 1'b0; y_valid = 1'b0;
    chk("fl_out_kept", 32'(word_out),   32'hF0);
    chk("fl_valid",    32'(word_valid), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send_bits(8'h81, 7, 5, 1'b0);
    chk("fl_no_early", 32'(word_valid), 32'd0);
    send_bits(8'h81, 4, 0, 1'b0);
    chk("fl_word", 32'(word_out),   32'h81);
    chk("fl_ones", 32'(ones_count), 32'd2);
`ifdef Y_WORD_PACKER_PARITY_EN
    chk("fl_par", 32'(word_parity), 32'd0);
`endif

    // reset mid-word with word held and overflow set
    send_bits(8'hFE, 7, 0, 1'b0);
    chk("pre_ovf", 32'(overflow), 32'd1);
    send_bits(8'hFF, 7, 5, 1'b0);
    do_reset();
    chk("mr_valid", 32'(word_valid), 32'd0);
    chk("mr_word",  32'(word_out),   32'd0);
    chk("mr_ones",  32'(ones_count), 32'd0);
    chk("mr_ovf",   32'(overflow),   32'd0);
`ifdef Y_WORD_PACKER_PARITY_EN
    chk("mr_par",   32'(word_parity), 32'd0);
`endif
    out_ready = 1'b1;
    send_bits(8'h01, 7, 0, 1'b0);
    chk("01_valid", 32'(word_valid), 32'd1);
    chk("01_word",  32'(word_out),   32'h01);
    chk("01_ones",  32'(ones_count), 32'd1);
`ifdef Y_WORD_PACKER_PARITY_EN
    chk("01_par",   32'(word_parity), 32'd1);
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
